// File: rtl/cu_ex_dispatch_if.sv
// CU-to-EX dispatch bus: ID request handshake, EX operand/result channel, writeback handshake.
// The master modport is the dispatcher; the slave modport is the surrounding pipeline.
interface cu_ex_dispatch_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs1;
    logic [31:0] id_rs2;
    logic [31:0] id_imm;
    logic [5:0]  id_instr;
    logic [4:0]  id_rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_data;
    logic [5:0]  Instruction_to_ALU;
    logic        ex_req;
    logic        EX_accept;
    logic        result_ready;
    logic [31:0] result_data;
    logic        overflow_flag;
    logic        zero_flag;
    logic        condition_met_flag;
    logic        error_flag;
    logic        ex_abort;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [3:0]  wb_flags;
    logic        wb_timeout;

    modport master (
        input  id_valid, id_rs1, id_rs2, id_imm, id_instr, id_rd,
        input  EX_accept, result_ready, result_data,
        input  overflow_flag, zero_flag, condition_met_flag, error_flag,
        input  wb_ready,
        output id_ready, rs1_data, rs2_data, imm_data, Instruction_to_ALU,
        output ex_req, ex_abort, wb_valid, wb_data, wb_rd, wb_flags, wb_timeout
    );

    modport slave (
        output id_valid, id_rs1, id_rs2, id_imm, id_instr, id_rd,
        output EX_accept, result_ready, result_data,
        output overflow_flag, zero_flag, condition_met_flag, error_flag,
        output wb_ready,
        input  id_ready, rs1_data, rs2_data, imm_data, Instruction_to_ALU,
        input  ex_req, ex_abort, wb_valid, wb_data, wb_rd, wb_flags, wb_timeout
    );
endinterface

// File: rtl/cu_ex_dispatch.sv
// Single-operation CU-to-EX dispatcher with an accept/result watchdog that aborts a hung EX
// stage and reports a timeout result to writeback.
module cu_ex_dispatch #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 8
) (
    input logic              soc_clk,
    input logic              reset,
    cu_ex_dispatch_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Last cycle a waiting state may spend before the watchdog fires.
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    logic [CNT_W-1:0] wdog_r;
    logic             id_ready_r;
    logic             ex_req_r;
    logic             ex_abort_r;
    logic             wb_valid_r;
    logic             wb_timeout_r;
    logic [31:0]      rs1_r;
    logic [31:0]      rs2_r;
    logic [31:0]      imm_r;
    logic [5:0]       instr_r;
    logic [4:0]       rd_r;
    logic [31:0]      wb_data_r;
    logic [3:0]       wb_flags_r;

    logic             take_result_s;
    logic             expired_s;
    logic [CNT_W-1:0] wdog_inc_s;

    // Result capture qualification and saturating watchdog increment.
    always_comb begin
        take_result_s = 1'b0;
        expired_s     = (wdog_r >= LIMIT_C);
        if (wdog_r == {CNT_W{1'b1}}) begin
            wdog_inc_s = wdog_r;
        end else begin
            wdog_inc_s = wdog_r + CNT_W'(1);
        end
        case (state_r)
            ST_ISSUE: take_result_s = bus.EX_accept & bus.result_ready;
            ST_WAIT:  take_result_s = bus.result_ready;
            default:  take_result_s = 1'b0;
        endcase
    end

    // Dispatch FSM with registered outputs.
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wdog_r       <= {CNT_W{1'b0}};
            id_ready_r   <= 1'b0;
            ex_req_r     <= 1'b0;
            ex_abort_r   <= 1'b0;
            wb_valid_r   <= 1'b0;
            wb_timeout_r <= 1'b0;
            rs1_r        <= 32'd0;
            rs2_r        <= 32'd0;
            imm_r        <= 32'd0;
            instr_r      <= 6'd0;
            rd_r         <= 5'd0;
            wb_data_r    <= 32'd0;
            wb_flags_r   <= 4'd0;
        end else begin
            ex_abort_r <= 1'b0;
            if (take_result_s) begin
                wb_data_r  <= bus.result_data;
                wb_flags_r <= {bus.overflow_flag, bus.zero_flag,
                               bus.condition_met_flag, bus.error_flag};
            end
            case (state_r)
                ST_IDLE: begin
                    id_ready_r <= 1'b1;
                    if (id_ready_r && bus.id_valid) begin
                        rs1_r      <= bus.id_rs1;
                        rs2_r      <= bus.id_rs2;
                        imm_r      <= bus.id_imm;
                        instr_r    <= bus.id_instr;
                        rd_r       <= bus.id_rd;
                        id_ready_r <= 1'b0;
                        ex_req_r   <= 1'b1;
                        wdog_r     <= {CNT_W{1'b0}};
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.EX_accept) begin
                        ex_req_r <= 1'b0;
                        wdog_r   <= {CNT_W{1'b0}};
                        if (take_result_s) begin
                            wb_valid_r <= 1'b1;
                            state_r    <= ST_HOLD;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else if (expired_s) begin
                        ex_req_r     <= 1'b0;
                        ex_abort_r   <= 1'b1;
                        wb_data_r    <= 32'd0;
                        wb_flags_r   <= 4'b0001;
                        wb_timeout_r <= 1'b1;
                        state_r      <= ST_ABORT;
                    end else begin
                        wdog_r <= wdog_inc_s;
                    end
                end
                ST_WAIT: begin
                    if (take_result_s) begin
                        wb_valid_r <= 1'b1;
                        state_r    <= ST_HOLD;
                    end else if (expired_s) begin
                        ex_abort_r   <= 1'b1;
                        wb_data_r    <= 32'd0;
                        wb_flags_r   <= 4'b0001;
                        wb_timeout_r <= 1'b1;
                        state_r      <= ST_ABORT;
                    end else begin
                        wdog_r <= wdog_inc_s;
                    end
                end
                ST_ABORT: begin
                    wb_valid_r <= 1'b1;
                    state_r    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.wb_ready) begin
                        wb_valid_r   <= 1'b0;
                        wb_timeout_r <= 1'b0;
                        id_ready_r   <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    ex_req_r   <= 1'b0;
                    wb_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.id_ready           = id_ready_r;
    assign bus.rs1_data           = rs1_r;
    assign bus.rs2_data           = rs2_r;
    assign bus.imm_data           = imm_r;
    assign bus.Instruction_to_ALU = instr_r;
    assign bus.ex_req             = ex_req_r;
    assign bus.ex_abort           = ex_abort_r;
    assign bus.wb_valid           = wb_valid_r;
    assign bus.wb_data            = wb_data_r;
    assign bus.wb_rd              = rd_r;
    assign bus.wb_flags           = wb_flags_r;
    assign bus.wb_timeout         = wb_timeout_r;
endmodule

// File: tb/tb_cu_ex_dispatch.sv
// Bench for cu_ex_dispatch: directed scenarios with literal expectations plus a
// deadline-based transaction model compared against the DUT on every falling edge.
module tb_cu_ex_dispatch;
    localparam int T = 15;

    logic soc_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   chk_en  = 1'b0;

    cu_ex_dispatch_if bus ();

    cu_ex_dispatch #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .soc_clk (soc_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 soc_clk = ~soc_clk;

    // Model state: what the dispatcher must be doing, with absolute-cycle deadlines.
    typedef enum int {M_IDLE, M_REQ, M_RES, M_ABT, M_WB} mph_t;
    mph_t        m_ph = M_IDLE;
    int          m_deadline = 0;
    logic        m_id_ready = 1'b0, m_ex_req = 1'b0, m_abort = 1'b0, m_wb_valid = 1'b0, m_to = 1'b0;
    logic [31:0] m_rs1 = 32'd0, m_rs2 = 32'd0, m_imm = 32'd0, m_wb_data = 32'd0;
    logic [5:0]  m_instr = 6'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [3:0]  m_flags = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge soc_clk) begin
        cyc++;
        if (reset) begin
            m_ph = M_IDLE; m_id_ready = 1'b0; m_ex_req = 1'b0; m_abort = 1'b0;
            m_wb_valid = 1'b0; m_to = 1'b0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_imm = 32'd0;
            m_instr = 6'd0; m_rd = 5'd0; m_wb_data = 32'd0; m_flags = 4'd0;
        end else begin
            m_abort = 1'b0;
            case (m_ph)
                M_IDLE: begin
                    if (m_id_ready && bus.id_valid) begin
                        m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2; m_imm = bus.id_imm;
                        m_instr = bus.id_instr; m_rd = bus.id_rd;
                        m_id_ready = 1'b0; m_ex_req = 1'b1;
                        m_deadline = cyc + T; m_ph = M_REQ;
                    end else m_id_ready = 1'b1;
                end
                M_REQ, M_RES: begin
                    if (m_ph == M_REQ && bus.EX_accept) begin
                        m_ex_req = 1'b0;
                        m_deadline = cyc + T;
                        m_ph = M_RES;
                        if (bus.result_ready) begin
                            m_wb_data = bus.result_data; m_wb_valid = 1'b1; m_ph = M_WB;
                            m_flags = {bus.overflow_flag, bus.zero_flag, bus.condition_met_flag, bus.error_flag};
                        end
                    end else if (m_ph == M_RES && bus.result_ready) begin
                        m_wb_data = bus.result_data; m_wb_valid = 1'b1; m_ph = M_WB;
                        m_flags = {bus.overflow_flag, bus.zero_flag, bus.condition_met_flag, bus.error_flag};
                    end else if (cyc == m_deadline) begin
                        m_ex_req = 1'b0; m_abort = 1'b1; m_wb_data = 32'd0;
                        m_flags = 4'b0001; m_to = 1'b1; m_ph = M_ABT;
                    end
                end
                M_ABT: begin m_wb_valid = 1'b1; m_ph = M_WB; end
                M_WB: if (bus.wb_ready) begin
                    m_wb_valid = 1'b0; m_to = 1'b0; m_id_ready = 1'b1; m_ph = M_IDLE;
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge soc_clk) begin
        if (chk_en) begin
            chk("id_ready", {31'd0, bus.id_ready}, {31'd0, m_id_ready});
            chk("ex_req", {31'd0, bus.ex_req}, {31'd0, m_ex_req});
            chk("ex_abort", {31'd0, bus.ex_abort}, {31'd0, m_abort});
            chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_wb_valid});
            chk("wb_timeout", {31'd0, bus.wb_timeout}, {31'd0, m_to});
            chk("rs1_data", bus.rs1_data, m_rs1);
            chk("rs2_data", bus.rs2_data, m_rs2);
            chk("imm_data", bus.imm_data, m_imm);
            chk("opcode", {26'd0, bus.Instruction_to_ALU}, {26'd0, m_instr});
            if (m_wb_valid) begin
                chk("wb_data", bus.wb_data, m_wb_data);
                chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, m_rd});
                chk("wb_flags", {28'd0, bus.wb_flags}, {28'd0, m_flags});
            end
        end
    end

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    // Offer an operation in IDLE and return one cycle after the handshake (first ISSUE cycle).
    task automatic dispatch(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op, input logic [4:0] rd);
        int n;
        n = 0;
        while (!bus.id_ready && n < 20) begin tick(); n++; end
        chk("id_ready_before_dispatch", {31'd0, bus.id_ready}, 32'd1);
        bus.id_valid = 1'b1; bus.id_rs1 = a; bus.id_rs2 = b; bus.id_imm = 32'h10; bus.id_instr = op; bus.id_rd = rd;
        tick();
        bus.id_valid = 1'b0;
        chk("ex_req_latency", {31'd0, bus.ex_req}, 32'd1);
    endtask

    // Wait for ex_abort, returning the number of cycles spent waiting.
    task automatic wait_abort(output int n);
        n = 0;
        while (!bus.ex_abort && n < 40) begin tick(); n++; end
    endtask

    initial begin
        int n;
        bus.id_valid = 1'b0; bus.id_rs1 = 32'd0; bus.id_rs2 = 32'd0; bus.id_imm = 32'd0;
        bus.id_instr = 6'd0; bus.id_rd = 5'd0; bus.EX_accept = 1'b0; bus.result_ready = 1'b0;
        bus.result_data = 32'd0; bus.overflow_flag = 1'b0; bus.zero_flag = 1'b0;
        bus.condition_met_flag = 1'b0; bus.error_flag = 1'b0; bus.wb_ready = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_id_ready", {31'd0, bus.id_ready}, 32'd0);
        chk("reset_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("reset_wb_data", bus.wb_data, 32'd0);
        reset = 1'b0;
        tick(); tick();
        chk("id_ready_after_reset", {31'd0, bus.id_ready}, 32'd1);

        // Basic ADD: stray result_ready in ISSUE without accept must be ignored.
        dispatch(32'd5, 32'd7, 6'd1, 5'd3);
        bus.result_ready = 1'b1; bus.result_data = 32'd99;
        tick();
        bus.result_ready = 1'b0;
        tick();
        bus.EX_accept = 1'b1;
        tick();
        bus.EX_accept = 1'b0; bus.result_ready = 1'b1; bus.result_data = 32'd12;
        tick();
        bus.result_ready = 1'b0;
        chk("basic_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("basic_wb_data", bus.wb_data, 32'd12);
        chk("basic_wb_rd", {27'd0, bus.wb_rd}, 32'd3);
        chk("basic_wb_flags", {28'd0, bus.wb_flags}, 32'd0);
        tick();
        chk("basic_wb_valid_drop", {31'd0, bus.wb_valid}, 32'd0);
        chk("basic_id_ready_back", {31'd0, bus.id_ready}, 32'd1);

        // Writeback stall with a competing ID request.
        bus.wb_ready = 1'b0;
        dispatch(32'hA5A5_0001, 32'h2, 6'd4, 5'd9);
        bus.EX_accept = 1'b1; bus.result_ready = 1'b1; bus.result_data = 32'hCAFE_F00D;
        bus.condition_met_flag = 1'b1;
        tick();
        bus.EX_accept = 1'b0; bus.result_ready = 1'b0; bus.condition_met_flag = 1'b0;
        bus.id_valid = 1'b1; bus.id_rs1 = 32'h1234; bus.id_rd = 5'd1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
            chk("stall_wb_data", bus.wb_data, 32'hCAFE_F00D);
            chk("stall_wb_flags", {28'd0, bus.wb_flags}, 32'b0010);
            chk("stall_id_ready", {31'd0, bus.id_ready}, 32'd0);
            chk("stall_rs1_kept", bus.rs1_data, 32'hA5A5_0001);
            tick();
        end
        bus.id_valid = 1'b0; bus.wb_ready = 1'b1;
        tick();
        chk("stall_release", {31'd0, bus.wb_valid}, 32'd0);

        // Accept timeout.
        dispatch(32'd1, 32'd2, 6'd2, 5'd4);
        wait_abort(n);
        chk("accept_timeout_cycles", n, T);
        chk("accept_to_flag", {31'd0, bus.wb_timeout}, 32'd1);
        chk("accept_to_data", bus.wb_data, 32'd0);
        chk("accept_to_flags", {28'd0, bus.wb_flags}, 32'b0001);
        tick();
        chk("accept_to_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("accept_to_abort_pulse", {31'd0, bus.ex_abort}, 32'd0);
        tick();
        chk("accept_to_cleared", {31'd0, bus.wb_timeout}, 32'd0);

        // Result timeout: accept on the first ISSUE cycle, no result.
        dispatch(32'd3, 32'd4, 6'd3, 5'd5);
        bus.EX_accept = 1'b1;
        tick();
        bus.EX_accept = 1'b0;
        wait_abort(n);
        chk("result_timeout_cycles", n, T);
        chk("result_to_flags", {28'd0, bus.wb_flags}, 32'b0001);
        tick();
        chk("result_to_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("result_to_wb_timeout", {31'd0, bus.wb_timeout}, 32'd1);
        tick();

        // Same-cycle accept and result with overflow.
        dispatch(32'hFFFF_FFFF, 32'd0, 6'd1, 5'd31);
        bus.EX_accept = 1'b1; bus.result_ready = 1'b1; bus.result_data = 32'hFFFF_FFFF;
        bus.overflow_flag = 1'b1; bus.zero_flag = 1'b0;
        tick();
        bus.EX_accept = 1'b0; bus.result_ready = 1'b0; bus.overflow_flag = 1'b0;
        chk("same_cycle_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("same_cycle_flags", {28'd0, bus.wb_flags}, 32'b1000);
        chk("same_cycle_data", bus.wb_data, 32'hFFFF_FFFF);
        tick();

        // Reset in WAIT drops the operation.
        dispatch(32'd8, 32'd9, 6'd5, 5'd6);
        bus.EX_accept = 1'b1;
        tick();
        bus.EX_accept = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wait_ex_req", {31'd0, bus.ex_req}, 32'd0);
        chk("rst_wait_rs1", bus.rs1_data, 32'd0);
        chk("rst_wait_id_ready", {31'd0, bus.id_ready}, 32'd0);
        bus.result_ready = 1'b1; bus.result_data = 32'd77;
        tick();
        bus.result_ready = 1'b0;
        chk("rst_wait_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wait_id_ready_up", {31'd0, bus.id_ready}, 32'd1);
        tick(); tick();
        chk("rst_wait_still_no_wb", {31'd0, bus.wb_valid}, 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
